led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1_000_000, is the press-qualification window in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter STEP_CYC, default 50_000_000, is the base pattern step period in clk cycles (1 s at 50 MHz).
REQ-003 Port clk, input, 1 bit: single system clock; all logic on the rising edge.
REQ-004 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port key, input, 4 bits: raw asynchronous push-buttons, active-low (pressed = 0).
REQ-006 Port led, output, 4 bits: LED drive, active-high.
REQ-007 Port mode, output, 2 bits: current mode; 0 = STATIC, 1 = FLOW, 2 = BLINK; 3 is never driven.
REQ-008 Port paused, output, 1 bit: high while pattern stepping is frozen.

Function
REQ-009 Each key bit SHALL pass a 2-flop synchronizer (s0 then s1); a falling edge is s0 = 0 and s1 = 1.
REQ-010 On a falling edge, the key's debounce counter SHALL load DEBOUNCE_CYC, restarting the count if one is already running.
REQ-011 The counter SHALL then decrement once per cycle while nonzero.
REQ-012 In the cycle the counter equals 1, if s0 = 0, pending[i] SHALL be set on the next edge; otherwise the press is discarded.
REQ-013 A confirmation for a key whose pending bit is already set SHALL merge into that bit; no counting or queueing.
REQ-014 Arbiter: each cycle at most one pending bit SHALL be granted, round-robin, starting the search at ptr.
REQ-015 On a grant, the granted bit SHALL clear, its action SHALL execute on the same edge, and ptr SHALL become granted index + 1 mod 4.
REQ-016 A confirmation and a grant of the same key in the same cycle SHALL leave pending set.
REQ-017 Key0 action: mode steps STATIC -> FLOW -> BLINK -> STATIC; paused clears and the step counter resets to 0.
REQ-018 Key1 action: speed steps 0 -> 1 -> 2 -> 0; the step counter resets to 0.
REQ-019 Key2 action: toggle dir.
REQ-020 Key3 action: toggle paused, only when mode is not STATIC; in STATIC it is ignored.
REQ-021 Step period SHALL be STEP_CYC >> speed.
REQ-022 The step counter SHALL count 0 to period-1 and wrap to 0; tick is asserted in the wrap cycle.
REQ-023 The step counter SHALL hold while paused and SHALL be held at 0 in STATIC.
REQ-024 Mode entry (on the key0 edge): STATIC sets led = 0000, FLOW sets led = 0001, BLINK sets led = 1111.
REQ-025 FLOW tick, dir = 0: led SHALL rotate left (0001 -> 0010 -> 0100 -> 1000 -> 0001).
REQ-026 FLOW tick, dir = 1: led SHALL rotate right.
REQ-027 BLINK tick: led SHALL invert.
REQ-028 Latency: pending is set DEBOUNCE_CYC+1 cycles after the edge-detect cycle; the action takes effect at the grant edge, 1 cycle later if no contention.
REQ-029 Changes to dir or speed SHALL NOT alter the current led value.

Reset
REQ-030 rstn low SHALL asynchronously force the following values:
- synchronizers = 1111; debounce counters = 0; pending = 0; ptr = 0
- mode = STATIC; speed = 0; dir = 0; paused = 0
- step counter = 0; led = 0000
REQ-031 Reset mid-debounce or mid-pattern SHALL discard all pending presses; there is no post-reset action.

Structure
REQ-032 Mode encodings (STATIC/FLOW/BLINK), speed codes (0..2) and key-to-action index constants SHALL live in a shared package, led_seq_pkg.
REQ-033 Per-key synchronizer, edge detect and debounce SHALL be one sub-module, key_debounce, instantiated 4 times; its output is a single-cycle confirm pulse.
REQ-034 The arbiter, mode/pattern FSM and step counter SHALL reside in led_seq_ctrl.

Verification (DEBOUNCE_CYC = 8, STEP_CYC = 16)
REQ-035 Single press: key0 held low 20 cycles -> mode 0 -> 1, led = 0001 exactly 1 cycle after the pending bit sets.
REQ-036 Bounce: key0 low 5 cycles, high, then low 20 cycles -> exactly one mode change; the confirm occurs 8 cycles after the second falling edge.
REQ-037 FLOW at speed 0: led 0001 -> 0010 -> 0100 -> 1000 -> 0001 at 16-cycle ticks.
REQ-038 FLOW speed and direction:
- key1 pressed twice -> ticks every 4 cycles
- key2 pressed -> rotation reverses with no led glitch
REQ-039 Simultaneous confirm of key1 and key2 with ptr = 0 -> key1 acts in cycle N, key2 in cycle N+1, and ptr ends at 3.
REQ-040 Pause and reset:
- BLINK with key3 pressed -> led frozen and paused = 1
- key3 pressed again -> stepping resumes
- rstn pulsed low mid-debounce -> all outputs at reset values immediately and no action after release

Source files
------------

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode, speed and key-index definitions for the LED sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_FLOW   = 2'd1,
    MODE_BLINK  = 2'd2
  } mode_e;

  localparam logic [1:0] SPEED_0 = 2'd0;
  localparam logic [1:0] SPEED_1 = 2'd1;
  localparam logic [1:0] SPEED_2 = 2'd2;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_MODE  = 0;
  localparam int KEY_SPEED = 1;
  localparam int KEY_DIR   = 2;
  localparam int KEY_PAUSE = 3;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_STATIC: next_mode = MODE_FLOW;
      MODE_FLOW:   next_mode = MODE_BLINK;
      default:     next_mode = MODE_STATIC;
    endcase
  endfunction

  function automatic logic [3:0] entry_led(input mode_e m);
    case (m)
      MODE_FLOW:  entry_led = 4'b0001;
      MODE_BLINK: entry_led = 4'b1111;
      default:    entry_led = 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] next_speed(input logic [1:0] s);
    next_speed = (s == SPEED_2) ? SPEED_0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchronizer, falling-edge detect and press qualification
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key,
  output logic confirm
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          s0;
  logic          s1;
  logic [CW-1:0] cnt;
  logic          fall;

  assign fall = ~s0 & s1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0  <= 1'b1;
      s1  <= 1'b1;
      cnt <= '0;
    end else begin
      s0 <= key;
      s1 <= s0;
      // a fresh edge restarts the window so bounces only delay qualification
      if (fall)
        cnt <= CW'(DEBOUNCE_CYC);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  assign confirm = (cnt == CW'(1)) & ~s0;

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - key arbiter, mode/pattern FSM and step timer driving four LEDs
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int STEP_CYC     = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] key,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       paused
);

  localparam int SW = $clog2(STEP_CYC + 1);

  logic [3:0]    confirm;
  logic [3:0]    pending;
  logic [3:0]    grant;
  logic [1:0]    ptr;
  logic [1:0]    gnt_idx;
  logic [1:0]    idx;
  logic          gnt_valid;
  mode_e         mode_q;
  logic [1:0]    speed;
  logic          dir;
  logic [SW-1:0] step_cnt;
  logic [SW-1:0] period;
  logic          tick;
  logic          step_rst;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_debounce (
      .clk     (clk),
      .rstn    (rstn),
      .key     (key[i]),
      .confirm (confirm[i])
    );
  end

  always_comb begin
    grant     = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      idx = ptr + 2'(k);
      if (!gnt_valid && pending[idx]) begin
        gnt_valid    = 1'b1;
        gnt_idx      = idx;
        grant[idx]   = 1'b1;
      end
    end
  end

  // a confirm arriving with its own grant re-arms the bit rather than being lost
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
      ptr     <= '0;
    end else begin
      pending <= (pending & ~grant) | confirm;
      if (gnt_valid)
        ptr <= gnt_idx + 2'd1;
    end
  end

  assign period   = SW'(STEP_CYC >> speed);
  assign tick     = (mode_q != MODE_STATIC) && !paused && (step_cnt == period - SW'(1));
  assign step_rst = grant[KEY_MODE] | grant[KEY_SPEED];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= MODE_STATIC;
      speed    <= SPEED_0;
      dir      <= 1'b0;
      paused   <= 1'b0;
      step_cnt <= '0;
      led      <= 4'b0000;
    end else begin
      if (grant[KEY_MODE]) begin
        mode_q <= next_mode(mode_q);
        led    <= entry_led(next_mode(mode_q));
        paused <= 1'b0;
      end else if (tick && !grant[KEY_SPEED]) begin
        case (mode_q)
          MODE_FLOW:  led <= dir ? {led[0], led[3:1]} : {led[2:0], led[3]};
          MODE_BLINK: led <= ~led;
          default:    led <= led;
        endcase
      end

      if (grant[KEY_SPEED])
        speed <= next_speed(speed);
      if (grant[KEY_DIR])
        dir <= ~dir;
      if (grant[KEY_PAUSE] && (mode_q != MODE_STATIC))
        paused <= ~paused;

      if ((mode_q == MODE_STATIC) || step_rst)
        step_cnt <= '0;
      else if (paused)
        step_cnt <= step_cnt;
      else if (tick)
        step_cnt <= '0;
      else
        step_cnt <= step_cnt + SW'(1);
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed and randomized checks of led_seq_ctrl against a behavioural model
module tb_led_seq_ctrl;

  localparam int DB = 8;
  localparam int ST = 16;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] key  = 4'hF;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;

  always #5 clk = ~clk;

  led_seq_ctrl #(.DEBOUNCE_CYC(DB), .STEP_CYC(ST)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .key    (key),
    .led    (led),
    .mode   (mode),
    .paused (paused)
  );

  int checks = 0;
  int errors = 0;

  int     m_mode, m_speed, m_dir, m_paused, m_led, m_phase, m_ptr;
  int     m_pend[4];
  int     m_s0[4];
  int     m_s1[4];
  longint m_dl[4];
  longint cyc_n = 0;
  int     led_changes = 0;
  int     mode_changes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_speed = 0; m_dir = 0; m_paused = 0;
    m_led = 0; m_phase = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_s0[i] = 1; m_s1[i] = 1; m_dl[i] = -1;
    end
  endtask

  task automatic model_step();
    int conf[4];
    int g, period, tick, srst, nphase, nm;
    for (int i = 0; i < 4; i++)
      conf[i] = (m_dl[i] == cyc_n && m_s0[i] == 0) ? 1 : 0;
    g = -1;
    for (int k = 0; k < 4; k++)
      if (g < 0 && m_pend[(m_ptr + k) % 4] != 0) g = (m_ptr + k) % 4;
    period = ST >> m_speed;
    tick   = (m_mode != 0 && m_paused == 0 && m_phase == period - 1) ? 1 : 0;
    srst   = (g == 0 || g == 1) ? 1 : 0;
    if (m_mode == 0 || srst != 0) nphase = 0;
    else if (m_paused != 0)       nphase = m_phase;
    else if (tick != 0)           nphase = 0;
    else                          nphase = m_phase + 1;
    if (g == 0) begin
      nm       = (m_mode + 1) % 3;
      m_mode   = nm;
      m_led    = (nm == 0) ? 0 : (nm == 1) ? 1 : 15;
      m_paused = 0;
    end else if (tick != 0 && g != 1) begin
      if (m_mode == 1)
        m_led = (m_dir != 0) ? ((m_led >> 1) | ((m_led & 1) << 3))
                             : (((m_led << 1) | (m_led >> 3)) & 15);
      else
        m_led = m_led ^ 15;
    end
    if (g == 1) m_speed = (m_speed + 1) % 3;
    if (g == 2) m_dir = 1 - m_dir;
    if (g == 3 && m_mode != 0) m_paused = 1 - m_paused;
    m_phase = nphase;
    for (int i = 0; i < 4; i++)
      m_pend[i] = ((m_pend[i] != 0 && i != g) || conf[i] != 0) ? 1 : 0;
    if (g >= 0) m_ptr = (g + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (m_s0[i] == 0 && m_s1[i] == 1) m_dl[i] = cyc_n + DB;
      m_s1[i] = m_s0[i];
      m_s0[i] = int'(key[i]);
    end
  endtask

  task automatic cyc(input int n);
    logic [3:0] prev_led;
    logic [1:0] prev_mode;
    for (int c = 0; c < n; c++) begin
      prev_led  = led;
      prev_mode = mode;
      if (rstn) model_step();
      else      model_reset();
      cyc_n++;
      @(posedge clk);
      #1;
      check("model_led", 32'(led), 32'(m_led));
      check("model_mode", 32'(mode), 32'(m_mode));
      check("model_paused", 32'(paused), 32'(m_paused));
      if (led !== prev_led) led_changes++;
      if (mode !== prev_mode) mode_changes++;
    end
  endtask

  task automatic press(input logic [3:0] mask, input int n_low, input int n_gap);
    key = key & ~mask;
    cyc(n_low);
    key = key | mask;
    cyc(n_gap);
  endtask

  initial begin
    logic [3:0] held;
    logic [3:0] mask;
    int m0;

    model_reset();
    #2;
    check("reset_led", 32'(led), 32'h0);
    check("reset_mode", 32'(mode), 32'h0);
    check("reset_paused", 32'(paused), 32'h0);
    cyc(3);
    rstn = 1'b1;
    cyc(4);

    // single press: mode changes on the 11th edge after the key drops
    key[0] = 1'b0;
    cyc(10);
    check("press_latency_before", 32'(mode), 32'd0);
    cyc(1);
    check("press_mode", 32'(mode), 32'd1);
    check("press_led", 32'(led), 32'h1);
    cyc(9);
    key[0] = 1'b1;
    cyc(5);

    led_changes = 0;
    cyc(64);
    check("flow_speed0_steps", 32'(led_changes), 32'd4);

    press(4'b0010, 15, 5);
    press(4'b0010, 15, 5);
    led_changes = 0;
    cyc(32);
    check("flow_speed2_steps", 32'(led_changes), 32'd8);

    press(4'b0100, 15, 40);

    press(4'b1000, 15, 5);
    check("flow_paused", 32'(paused), 32'd1);
    held = led;
    led_changes = 0;
    cyc(20);
    check("flow_frozen", 32'(led_changes), 32'd0);
    press(4'b1000, 15, 5);
    check("flow_resumed", 32'(paused), 32'd0);

    press(4'b0110, 15, 40);

    // bounce on key0: the short first low must not qualify
    m0 = mode_changes;
    key[0] = 1'b0; cyc(5);
    key[0] = 1'b1; cyc(6);
    key[0] = 1'b0; cyc(10);
    check("bounce_before", 32'(mode), 32'd1);
    cyc(1);
    check("bounce_mode", 32'(mode), 32'd2);
    cyc(9);
    key[0] = 1'b1; cyc(20);
    check("bounce_once", 32'(mode_changes - m0), 32'd1);

    press(4'b1000, 15, 5);
    check("blink_paused", 32'(paused), 32'd1);
    held = led;
    led_changes = 0;
    cyc(40);
    check("blink_frozen", 32'(led), 32'(held));
    check("blink_no_steps", 32'(led_changes), 32'd0);
    press(4'b1000, 15, 5);
    check("blink_resumed", 32'(paused), 32'd0);
    led_changes = 0;
    cyc(40);
    check("blink_stepping", 32'(led_changes >= 2), 32'd1);

    // reset mid-debounce
    key[0] = 1'b0;
    cyc(4);
    key = 4'hF;
    rstn = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'h0);
    check("async_reset_mode", 32'(mode), 32'h0);
    check("async_reset_paused", 32'(paused), 32'h0);
    model_reset();
    cyc(3);
    rstn = 1'b1;
    m0 = mode_changes;
    cyc(30);
    check("no_post_reset_action", 32'(mode_changes - m0), 32'd0);

    for (int r = 0; r < 60; r++) begin
      mask = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) mask = mask | 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        key = key & ~mask; cyc($urandom_range(1, 6));
        key = key | mask;  cyc($urandom_range(1, 4));
      end
      press(mask, $urandom_range(1, 20), $urandom_range(1, 30));
      if ($urandom_range(0, 24) == 0) begin
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
